// File: rtl/psg_env_mixer.sv
// Envelope-scaled channel mixer: one product per cnt slot, summed per frame, saturated 16-bit out.
// Optional per-frame output gain (<<< 0..3) enabled by defining PSG_MIX_GAIN_EN.
module psg_env_mixer #(
  parameter int pChannels      = 4,
  parameter int pPrescalerBits = 5,
  parameter int pShift         = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [pPrescalerBits-1:0] cnt,
  input  logic [7:0]                env,
  input  logic [11:0]               wave0,
  input  logic [11:0]               wave1,
  input  logic [11:0]               wave2,
  input  logic [11:0]               wave3,
  input  logic [3:0]                mute,
`ifdef PSG_MIX_GAIN_EN
  input  logic [1:0]                gain,
`endif
  output logic [15:0]               o,
  output logic                      o_vld
);

  localparam logic [pPrescalerBits-1:0] NUM_SLOTS = pPrescalerBits'(pChannels);
  localparam logic [1:0]                LAST_TAG  = 2'(pChannels - 1);

  logic [11:0]        wave_arr [4];
  logic [1:0]         ch;
  logic               slot_active;
  logic signed [20:0] mult;

  logic signed [20:0] prod_q, prod_d;
  logic [1:0]         prod_tag_q, prod_tag_d;
  logic               prod_vld_q, prod_vld_d;
  logic signed [22:0] acc_q, acc_d;
  logic               frame_ok_q, frame_ok_d;
  logic               last_q, last_d;
  logic [15:0]        o_q, o_d;
  logic               o_vld_q, o_vld_d;

  logic signed [22:0] prod_ext;
  logic signed [22:0] shifted;
  logic signed [25:0] scaled;
  logic [15:0]        sat;

  assign wave_arr[0] = wave0;
  assign wave_arr[1] = wave1;
  assign wave_arr[2] = wave2;
  assign wave_arr[3] = wave3;

  // Stage 1: only the channel owning the current slot is sampled.
  always_comb begin
    ch          = cnt[1:0];
    slot_active = (cnt < NUM_SLOTS);
    mult        = $signed(wave_arr[ch]) * $signed({1'b0, env});
    prod_d      = prod_q;
    prod_tag_d  = prod_tag_q;
    prod_vld_d  = slot_active;
    if (slot_active) begin
      prod_d     = mute[ch] ? '0 : mult;
      prod_tag_d = ch;
    end
  end

  // Stage 2: channel 0 reloads the accumulator, so no explicit frame clear is needed.
  always_comb begin
    prod_ext   = $signed({{2{prod_q[20]}}, prod_q});
    acc_d      = acc_q;
    frame_ok_d = frame_ok_q;
    last_d     = prod_vld_q && (prod_tag_q == LAST_TAG);
    if (prod_vld_q) begin
      if (prod_tag_q == 2'd0) begin
        acc_d      = prod_ext;
        frame_ok_d = 1'b1;
      end else begin
        acc_d = acc_q + prod_ext;
      end
    end
  end

  // Stage 3: scale, saturate, publish once per frame.
  always_comb begin
    shifted = acc_q >>> pShift;
    scaled  = $signed({{3{shifted[22]}}, shifted});
`ifdef PSG_MIX_GAIN_EN
    scaled  = scaled <<< gain;
`endif
    if (scaled > 26'sd32767) begin
      sat = 16'h7fff;
    end else if (scaled < -26'sd32768) begin
      sat = 16'h8000;
    end else begin
      sat = scaled[15:0];
    end
    o_d     = o_q;
    o_vld_d = 1'b0;
    if (last_q && frame_ok_q) begin
      o_d     = sat;
      o_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q     <= '0;
      prod_tag_q <= '0;
      prod_vld_q <= 1'b0;
      acc_q      <= '0;
      frame_ok_q <= 1'b0;
      last_q     <= 1'b0;
      o_q        <= '0;
      o_vld_q    <= 1'b0;
    end else begin
      prod_q     <= prod_d;
      prod_tag_q <= prod_tag_d;
      prod_vld_q <= prod_vld_d;
      acc_q      <= acc_d;
      frame_ok_q <= frame_ok_d;
      last_q     <= last_d;
      o_q        <= o_d;
      o_vld_q    <= o_vld_d;
    end
  end

  assign o     = o_q;
  assign o_vld = o_vld_q;

endmodule

// File: tb/tb_psg_env_mixer.sv
// Bench for psg_env_mixer: directed frame table plus randomized frames against an arithmetic model.
module tb_psg_env_mixer;

`ifdef PSG_MIX_GAIN_EN
  localparam bit GAIN_ON = 1'b1;
`else
  localparam bit GAIN_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  cnt = '0;
  logic [7:0]  env = '0;
  logic [11:0] wave0 = '0, wave1 = '0, wave2 = '0, wave3 = '0;
  logic [3:0]  mute = '0;
`ifdef PSG_MIX_GAIN_EN
  logic [1:0]  gain = '0;
`endif
  logic [15:0] o;
  logic        o_vld;

  int n_pass  = 0;
  int n_total = 0;
  int cur_o   = 0;

  always #5 clk = ~clk;

  psg_env_mixer dut (
    .clk   (clk),
    .rst   (rst),
    .cnt   (cnt),
    .env   (env),
    .wave0 (wave0),
    .wave1 (wave1),
    .wave2 (wave2),
    .wave3 (wave3),
    .mute  (mute),
`ifdef PSG_MIX_GAIN_EN
    .gain  (gain),
`endif
    .o     (o),
    .o_vld (o_vld)
  );

  typedef struct {
    logic [3:0][11:0] w;
    logic [3:0][7:0]  e;
    logic [3:0]       m;
    logic [1:0]       g;
    int               rlo;
    int               rhi;
    int               exp_o;
    bit               exp_vld;
  } vec_t;

  function automatic vec_t mk(int w, int e, logic [3:0] m, logic [1:0] g,
                              int rlo, int rhi, int exp_o, bit exp_vld);
    vec_t v;
    for (int i = 0; i < 4; i++) begin
      v.w[i] = 12'(w);
      v.e[i] = 8'(e);
    end
    v.m = m; v.g = g; v.rlo = rlo; v.rhi = rhi;
    v.exp_o = exp_o; v.exp_vld = exp_vld;
    return v;
  endfunction

  // Reference: sum of unmuted wave*env, floor-divide by 64, optional gain, clamp to 16 bits.
  function automatic int model(vec_t v);
    longint sum = 0;
    for (int i = 0; i < 4; i++)
      if (!v.m[i]) sum += longint'($signed(v.w[i])) * longint'(v.e[i]);
    sum = sum >>> 6;
    if (GAIN_ON) sum = sum * (longint'(1) << v.g);
    if (sum > 32767) sum = 32767;
    if (sum < -32768) sum = -32768;
    return int'(sum);
  endfunction

  task automatic check(string name, int slot, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s slot=%0d got=%0d expected=%0d", name, slot, act, exp);
  endtask

  task automatic set_wave(int s, logic [11:0] val);
    case (s)
      0: wave0 = val;
      1: wave1 = val;
      2: wave2 = val;
      default: wave3 = val;
    endcase
  endtask

  // One 32-slot frame; off-slot inputs are randomized to prove they are ignored.
  task automatic run_frame(vec_t v, int idx);
    int vld_seen = 0;
    for (int s = 0; s < 32; s++) begin
      rst   = (s >= v.rlo) && (s <= v.rhi);
      cnt   = 5'(s);
      env   = 8'($urandom);
      wave0 = 12'($urandom); wave1 = 12'($urandom);
      wave2 = 12'($urandom); wave3 = 12'($urandom);
      mute  = 4'($urandom);
`ifdef PSG_MIX_GAIN_EN
      gain  = (s == 5) ? v.g : 2'($urandom);
`endif
      if (s < 4) begin
        env     = v.e[s];
        set_wave(s, v.w[s]);
        mute[s] = v.m[s];
      end
      @(posedge clk);
      #1;
      if (rst) cur_o = 0;
      if (s == 5 && v.exp_vld) cur_o = v.exp_o;
      if (o_vld) vld_seen++;
      check("o_vld", s, int'(o_vld), (s == 5) ? int'(v.exp_vld) : 0);
      check("o", s, int'($signed(o)), cur_o);
    end
    $display("frame %0d rst=[%0d,%0d] o=%0d vld_count=%0d", idx, v.rlo, v.rhi, $signed(o), vld_seen);
  endtask

  vec_t tab [14];

  initial begin
    tab[0]  = mk(0, 0, 4'b0000, 2'd0, 0, 2, 0, 1'b0);
    tab[1]  = mk(2047, 0, 4'b0000, 2'd0, -1, -1, 8156, 1'b1);
    tab[1].e[0] = 8'd255;
    tab[2]  = mk(-2048, 255, 4'b0000, 2'd0, -1, -1, -32640, 1'b1);
    tab[3]  = mk(0, 128, 4'b0100, 2'd0, -1, -1, 0, 1'b1);
    tab[3].w[2] = 12'd1000;
    tab[4]  = mk(0, 128, 4'b0000, 2'd0, -1, -1, 2000, 1'b1);
    tab[4].w[2] = 12'd1000;
    tab[5]  = mk(500, 200, 4'b0000, 2'd0, 2, 2, 0, 1'b0);
    tab[6]  = mk(100, 10, 4'b0000, 2'd0, -1, -1, 62, 1'b1);
    tab[7]  = mk(-1, 1, 4'b0000, 2'd0, -1, -1, -1, 1'b1);
    tab[8]  = mk(2047, 255, 4'b0000, 2'd3, -1, -1, GAIN_ON ? 32767 : 32624, 1'b1);
    tab[9]  = mk(-2048, 255, 4'b0000, 2'd3, -1, -1, GAIN_ON ? -32768 : -32640, 1'b1);
    tab[10] = mk(2047, 255, 4'b0000, 2'd0, -1, -1, 32624, 1'b1);
    tab[11] = mk(1234, 99, 4'b1111, 2'd2, -1, -1, 0, 1'b1);
    tab[12] = mk(300, 50, 4'b0000, 2'd0, 20, 20, 937, 1'b1);
    tab[13] = mk(-2048, 255, 4'b1010, 2'd0, -1, -1, -16320, 1'b1);

    for (int i = 0; i < 14; i++) run_frame(tab[i], i);

    for (int f = 0; f < 40; f++) begin
      vec_t v;
      int r;
      v = mk(0, 0, 4'b0000, 2'd0, -1, -1, 0, 1'b0);
      for (int i = 0; i < 4; i++) begin
        v.w[i] = 12'($urandom);
        v.e[i] = 8'($urandom);
      end
      v.m = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      v.g = 2'($urandom);
      if ($urandom_range(0, 4) == 0) begin
        r = $urandom_range(0, 31);
        v.rlo = r;
        v.rhi = r;
      end
      v.exp_vld = !(v.rlo >= 0 && v.rlo <= 5);
      v.exp_o   = model(v);
      run_frame(v, 14 + f);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
